bon_gen: RTL and testbench

BON_GEN -- requirements
Module: bon_gen

---
 rtl/bon_pkg.sv | 28 ++
 rtl/bon_lfsr16.sv | 26 ++
 rtl/bon_gen.sv | 96 +++++++++
 tb/tb_bon_gen.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/bon_pkg.sv
// Shared constants and types for the pattern-counting LFSR write generator.
// Holds the state encoding, pattern, geometry, default seed and LFSR taps.
package bon_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam int PAT_LEN = 7;
  localparam int DEPTH   = 1024;
  localparam int ADDR_W  = 10;

  // Oldest stream bit is the MSB.
  localparam logic [PAT_LEN-1:0] PATTERN  = 7'b1010011;
  localparam logic [15:0]        DEF_SEED = 16'hACE1;

  localparam int TAP_A = 15;
  localparam int TAP_B = 13;
  localparam int TAP_C = 12;
  localparam int TAP_D = 10;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[TAP_A] ^ s[TAP_B] ^ s[TAP_C] ^ s[TAP_D]};
  endfunction

endpackage

// File: rtl/bon_lfsr16.sv
// 16-bit Fibonacci LFSR with synchronous reset, parallel load and step enable.
// Load has priority over step.
module bon_lfsr16
  import bon_pkg::*;
#(
  parameter logic [15:0] RST_VAL = DEF_SEED
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        step,
  output logic [15:0] q
);

  logic [15:0] r_q;

  always_ff @(posedge clk) begin
    if (rst)       r_q <= RST_VAL;
    else if (load) r_q <= load_val;
    else if (step) r_q <= lfsr_step(r_q);
  end

  assign q = r_q;

endmodule

// File: rtl/bon_gen.sv
// Writes DEPTH LFSR words to memory and counts overlapping occurrences of
// PATTERN in the stream of LFSR LSBs, reporting the count with a fin pulse.
module bon_gen
  import bon_pkg::*;
#(
  parameter logic [15:0] G_DEF_SEED = DEF_SEED
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [15:0]       seed,
  output logic              en,
  output logic [ADDR_W-1:0] addr,
  output logic [9:0]        data,
  output logic              busy,
  output logic              fin,
  output logic [9:0]        result
);

  state_t              r_state, w_nstate;
  logic [ADDR_W-1:0]   r_addr;
  logic [PAT_LEN-2:0]  r_hist;
  logic [2:0]          r_fill;
  logic [9:0]          r_result;

  logic                w_load, w_step, w_match;
  logic [15:0]         w_lfsr, w_load_val;
  logic [PAT_LEN-1:0]  w_window;

  assign w_load_val = (seed == 16'h0000) ? G_DEF_SEED : seed;

  bon_lfsr16 #(.RST_VAL(G_DEF_SEED)) u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .load     (w_load),
    .load_val (w_load_val),
    .step     (w_step),
    .q        (w_lfsr)
  );

  // The full 7-bit window is the stored six older bits plus the current bit;
  // r_fill gates matches until six earlier bits exist.
  assign w_window = {r_hist, w_lfsr[0]};
  assign w_match  = (w_window == PATTERN) && (r_fill == 3'(PAT_LEN - 1));

  always_comb begin
    w_nstate = r_state;
    w_load   = 1'b0;
    w_step   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_nstate = S_WRITE;
          w_load   = 1'b1;
        end
      end
      S_WRITE: begin
        w_step = 1'b1;
        if (r_addr == ADDR_W'(DEPTH - 1)) w_nstate = S_DONE;
      end
      S_DONE:  w_nstate = S_IDLE;
      default: w_nstate = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_addr   <= '0;
      r_hist   <= '0;
      r_fill   <= '0;
      r_result <= '0;
    end else begin
      r_state <= w_nstate;
      if (w_load) begin
        r_addr   <= '0;
        r_hist   <= '0;
        r_fill   <= '0;
        r_result <= '0;
      end else if (r_state == S_WRITE) begin
        r_addr <= r_addr + 1'b1;
        r_hist <= w_window[PAT_LEN-2:0];
        if (r_fill != 3'(PAT_LEN - 1)) r_fill <= r_fill + 1'b1;
        if (w_match) r_result <= r_result + 1'b1;
      end
    end
  end

  assign en     = (r_state == S_WRITE);
  assign busy   = (r_state == S_WRITE);
  assign fin    = (r_state == S_DONE);
  assign addr   = r_addr;
  assign data   = w_lfsr[9:0];
  assign result = r_result;

endmodule

// File: tb/tb_bon_gen.sv
// Scoreboard bench for bon_gen: stimulus pushes expected writes/results,
// a negedge monitor pops and compares whatever the DUT presents.
module tb_bon_gen;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [15:0] seed;
  logic        en, busy, fin;
  logic [9:0]  addr, data, result;

  bon_gen dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .seed   (seed),
    .en     (en),
    .addr   (addr),
    .data   (data),
    .busy   (busy),
    .fin    (fin),
    .result (result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [9:0] a;
    logic [9:0] d;
  } wr_t;

  wr_t        wq[$];
  int         rq[$];
  int         fq[$];
  int         n_cmp = 0;
  int         n_err = 0;
  logic [9:0] mem[1024];
  logic [9:0] first3[3];
  int         wr_idx = 0;
  wr_t        e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int mem_count();
    int c = 0;
    logic [6:0] w = '0;
    for (int k = 0; k < 1024; k++) begin
      w = {w[5:0], mem[k][0]};
      if (k >= 6 && w == 7'b1010011) c++;
    end
    return c;
  endfunction

  // Independent reference: step the LFSR, slide a 7-bit window over the LSBs.
  task automatic push_run(input logic [15:0] sd, input int c0);
    logic [15:0] s = (sd == 16'h0000) ? 16'hACE1 : sd;
    logic [6:0]  w = '0;
    int          cnt = 0;
    for (int k = 0; k < 1024; k++) begin
      wq.push_back('{a: 10'(k), d: s[9:0]});
      w = {w[5:0], s[0]};
      if (k >= 6 && w == 7'b1010011) cnt++;
      s = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    end
    rq.push_back(cnt);
    fq.push_back(c0 + 1025);
  endtask

  // Monitor
  initial forever begin
    @(negedge clk);
    if (en === 1'b1) begin
      if (wq.size() == 0) chk("unexpected_write", 1, 0);
      else begin
        e = wq.pop_front();
        chk("addr", addr, e.a);
        chk("data", data, e.d);
      end
      chk("busy_in_write", busy, 1);
      mem[addr] = data;
      if (wr_idx < 3) first3[wr_idx] = data;
      wr_idx++;
    end
    if (fin === 1'b1) begin
      if (rq.size() == 0) chk("unexpected_fin", 1, 0);
      else begin
        chk("result", result, rq.pop_front());
        chk("fin_cycle", cyc, fq.pop_front());
        chk("mem_model", result, mem_count());
        chk("fin_en_busy", {en, busy}, 0);
      end
    end
  end

  task automatic wait_done();
    for (int i = 0; i < 1200 && rq.size() > 0; i++) begin
      @(posedge clk); #1;
    end
    if (rq.size() > 0) begin
      chk("run_timeout", rq.size(), 0);
      wq.delete(); rq.delete(); fq.delete();
    end
  endtask

  task automatic run(input logic [15:0] sd, input bit hold);
    @(posedge clk); #1;
    wr_idx = 0;
    seed   = sd;
    start  = 1'b1;
    push_run(sd, cyc);
    if (!hold) begin
      @(posedge clk); #1;
      start = 1'b0;
      seed  = 16'(($urandom));
    end
    wait_done();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_run_idle", {en, busy, fin}, 0);
    end
    chk("queue_drained", wq.size(), 0);
  endtask

  logic [15:0] seeds[8] = '{16'hBEEF, 16'h8000, 16'hFFFF, 16'h5A5A,
                            16'h0F0F, 16'h1357, 16'hC0DE, 16'h0400};

  initial begin
    int c0;
    rst = 1'b1; start = 1'b1; seed = 16'h0001;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_outputs", {en, busy, fin}, 0);
    chk("rst_data", data, 10'h0E1);
    chk("rst_addr", addr, 0);
    chk("rst_result", result, 0);
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0; seed = 16'h0000;
    @(negedge clk);
    chk("post_rst_outputs", {en, busy, fin}, 0);
    chk("post_rst_data", data, 10'h0E1);
    chk("post_rst_result", result, 0);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("idle", {en, fin, result}, 0);
    end

    run(16'h0001, 1'b0);
    chk("seed1_w0", first3[0], 10'h001);
    chk("seed1_w1", first3[1], 10'h002);
    chk("seed1_w2", first3[2], 10'h004);

    run(16'h0000, 1'b0);
    chk("seed0_w0", first3[0], 10'h0E1);
    chk("seed0_result_hold", result, rq.size() == 0 ? result : 10'h3FF);
    run(16'hACE1, 1'b0);
    chk("aceseed_w0", first3[0], 10'h0E1);

    // start held high through the whole run
    run(16'h1234, 1'b1);
    chk("hold_writes", wr_idx, 1024);

    // reset in the middle of a run
    @(posedge clk); #1;
    seed = 16'h2468; start = 1'b1;
    c0 = cyc;
    push_run(16'h2468, c0);
    @(posedge clk); #1;
    start = 1'b0;
    while (cyc < c0 + 501) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    wq.delete(); rq.delete(); fq.delete();
    rst = 1'b0;
    @(negedge clk);
    chk("abort_en", {en, busy, fin}, 0);
    chk("abort_addr", addr, 0);
    chk("abort_result", result, 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("abort_quiet", {en, fin}, 0);
    end
    run(16'h2468, 1'b0);
    chk("after_abort_writes", wr_idx, 1024);

    foreach (seeds[i]) run(seeds[i], 1'b0);
    for (int i = 0; i < 12; i++) run(16'($urandom), 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
